// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter and its round-robin selector.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 200000;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set valid bit scanning upward from ptr+1 with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] winner
);

    logic [IW-1:0] idx;

    // Walk from the farthest candidate back to ptr+1 so the nearest set bit wins last.
    always_comb begin
        any    = |valid;
        winner = '0;
        idx    = '0;
        for (int i = N; i >= 1; i--) begin
            idx = IW'((int'(ptr) + i) % N);
            if (valid[idx]) winner = idx;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX among NUM_REQ byte sources.
// Optional watchdog on the TX done pulse is enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                        i_clk,
    input  logic                        i_aresetn,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]          o_req_ready,
    output logic                        o_tx_start,
    output logic [DATA_W-1:0]           o_tx_data,
    input  logic                        i_tx_done,
    output logic                        o_busy,
    output logic [grant_w(NUM_REQ)-1:0] o_grant_id,
    output logic                        o_timeout,
    output arb_state_t                  o_state
);

    localparam int ID_W = grant_w(NUM_REQ);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   grant_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              pick_any;
    logic [ID_W-1:0]   pick_id;
    logic              expire;
    logic [DATA_W-1:0] req_bytes [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_bytes[k] = i_req_data[k*DATA_W +: DATA_W];
    end

    rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
        .valid  (i_req_valid),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_id)
    );

    always_comb begin
        state_d     = state_q;
        o_req_ready = '0;
        o_tx_start  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    o_req_ready[pick_id] = 1'b1;
                    state_d              = START;
                end
            end
            START: begin
                o_tx_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (i_tx_done || expire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            state_q   <= IDLE;
            ptr_q     <= ID_W'(NUM_REQ - 1);
            grant_q   <= '0;
            tx_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_any) begin
                tx_data_q <= req_bytes[pick_id];
                grant_q   <= pick_id;
            end
            if (state_q == WAIT && (i_tx_done || expire)) ptr_q <= grant_q;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_q;

    assign expire = (state_q == WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // A done pulse coinciding with expiry is treated as a normal completion.
    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (state_q == START) wait_cnt_q <= '0;
            else if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;
            if (expire && !i_tx_done) timeout_q <= 1'b1;
        end
    end

    assign o_timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign expire             = 1'b0;
    assign o_timeout          = 1'b0;
`endif

    assign o_tx_data  = tx_data_q;
    assign o_grant_id = grant_q;
    assign o_busy     = (state_q != IDLE);
    assign o_state    = state_q;

endmodule
